spi_aes_multi_master: RTL and testbench
=======================================

// Module: spi_aes_multi_master
// PURPOSE
//  Parametrised SPI-style serial master that streams one 128-bit block and an Nk-word key
//  to one of NUM_CH AES engine slaves, then collects the 128-bit result from that slave.
//  It supersedes the fixed enc-then-dec sequencer and adds start/busy/done handshaking.
//  Any mix of cipher/inverse-cipher slaves can be selected per transaction.
//  It sits between the top-level block/key registers and the SPI slave wrappers.
// PARAMETERS
//  Nk      4   key length in 32-bit words (4/6/8); the key stream is Nk*32 bits
//  NUM_CH  2   number of attached slaves; one chip-select and one MISO per slave
//  GAP     4   turnaround cycles between the last key bit and the first result bit
//  SEL_W   1   width of sel; must satisfy 2**SEL_W >= NUM_CH
// PORTS
//  clk       in   1         single clock; all logic is on the posedge
//  rst       in   1         asynchronous reset, active-low
//  start     in   1         request a transaction; sampled only when busy=0
//  sel       in   SEL_W     target slave index; sampled together with start
//  data_in   in   128       block to send; bit 127 is sent first
//  key       in   Nk*32     key to send; bit Nk*32-1 is sent first
//  miso      in   NUM_CH    serial result line from each slave
//  mosi      out  1         shared serial data line to all slaves
//  cs_n      out  NUM_CH    active-low chip-selects; at most one bit is low at a time
//  busy      out  1         transaction in progress
//  done      out  1         one-cycle pulse; data_out is valid from this cycle
//  err       out  1         one-cycle pulse; a start with sel>=NUM_CH was rejected
//  data_out  out  128       last received result, first-received bit at [127]; held until next done
// BEHAVIOUR
//  Reset (rst=0, async) forces these values and returns the FSM to IDLE from any state:
//   mosi=0, cs_n=all 1, busy=0, done=0, err=0, data_out=0, counters=0.
//  States: IDLE -> SEND -> WAIT -> RECV -> DONE -> IDLE.
//  IDLE: on start=1 with sel<NUM_CH, latch data_in, key and sel into shadow registers.
//   Next cycle: enter SEND, set busy=1, drive cs_n[sel]=0, drive mosi=data_in[127].
//   Inputs may change after the start cycle.
//  IDLE: on start=1 with sel>=NUM_CH, pulse err for 1 cycle, stay in IDLE, keep busy=0.
//  SEND: one bit per cycle, S=128+Nk*32 cycles. The block is sent MSB-first, then the key MSB-first.
//  WAIT: GAP cycles with mosi=0 and cs_n[sel] still low. GAP=0 skips this state.
//  RECV: 128 cycles. Each posedge shifts miso[sel] into the LSB of a shift register; mosi=0.
//  DONE: one cycle. Copy the shift register to data_out, set done=1, set cs_n to all 1,
//   keep busy=1. In the next cycle, busy=0 and a new start is accepted.
//  Latency: start is sampled in cycle 0; done is high in cycle S+GAP+129.
//   Example: Nk=4, GAP=4 gives done in cycle 389.
//  start while busy=1 is ignored: not queued, and no err pulse.
//  Counters are sized to clog2(Nk*32+128) bits and clear on every state entry. No wrap is visible.
//  data_out changes only in DONE or on reset. A reset mid-transaction discards the partial result.
//  done and err are never high in the same cycle.
// TESTING
//  1 Reset: hold rst=0 with random inputs, release -> all outputs at reset values, cs_n all 1.
//  2 Nk=4, GAP=4, sel=0, data=00112233445566778899aabbccddeeff, key=000102..0f,
//    AES cipher slave -> done in cycle 389, data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
//  3 Same ciphertext and key to an inverse-cipher slave on sel=1 -> data_out=00112233..eeff;
//    only cs_n[1] is low throughout.
//  4 NUM_CH=2, start with sel=3 -> err pulses 1 cycle, busy stays 0, cs_n stays all 1.
//  5 Assert rst=0 in SEND cycle 50 -> cs_n all 1 at once; then a fresh start completes correctly.
//  6 Nk=8, start re-asserted on every cycle while busy -> one done exactly at cycle 128+256+GAP+129;
//    a second start is accepted the cycle after done.

Source files
------------

// File: rtl/spi_aes_multi_master.sv
// spi_aes_multi_master
//   Serial master that streams a 128-bit block followed by an Nk-word key to one
//   of NUM_CH AES engine slaves, waits GAP turnaround cycles, then shifts the
//   128-bit result back in from the selected slave's MISO line.
// Ports
//   clk       : single clock, posedge only
//   rst       : asynchronous reset, active-low
//   start/sel : transaction request and target slave, sampled while idle
//   data_in   : block to send, bit 127 first
//   key       : key to send, bit Nk*32-1 first
//   miso      : one serial result line per slave
//   mosi      : shared serial data line
//   cs_n      : active-low chip-selects, at most one low
//   busy      : transaction in progress
//   done      : one-cycle pulse, data_out valid from this cycle
//   err       : one-cycle pulse, start rejected because sel >= NUM_CH
//   data_out  : last received result, first-received bit at [127]
module spi_aes_multi_master #(
    parameter int Nk     = 4,
    parameter int NUM_CH = 2,
    parameter int GAP    = 4,
    parameter int SEL_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel,
    input  logic [127:0]      data_in,
    input  logic [Nk*32-1:0]  key,
    input  logic [NUM_CH-1:0] miso,
    output logic              mosi,
    output logic [NUM_CH-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [127:0]      data_out
);

    localparam int S  = 128 + Nk * 32;
    localparam int CW = $clog2(S);
    localparam int MW = 2 ** SEL_W;

    localparam logic [CW-1:0]     SEND_LAST = CW'(S - 1);
    localparam logic [CW-1:0]     WAIT_LAST = CW'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [CW-1:0]     RECV_LAST = CW'(127);
    localparam logic [SEL_W:0]    NUM_CH_V  = (SEL_W + 1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] CH0       = NUM_CH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [S-1:0]      tx_q, tx_d;
    logic [127:0]      rx_q, rx_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CH-1:0] cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [127:0]      dout_q, dout_d;

    // Pad miso to a power of two so a SEL_W-bit index never runs off the end.
    logic [MW-1:0] miso_ext;
    assign miso_ext = MW'(miso);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sel_d   = sel_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if ({1'b0, sel} < NUM_CH_V) begin
                        state_d = ST_SEND;
                        sel_d   = sel;
                        // First bit goes straight to mosi; the rest queue in tx.
                        mosi_d  = data_in[127];
                        tx_d    = {data_in[126:0], key, 1'b0};
                        cs_n_d  = ~(CH0 << sel);
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (cnt_q == SEND_LAST) begin
                    cnt_d   = '0;
                    mosi_d  = 1'b0;
                    state_d = (GAP == 0) ? ST_RECV : ST_WAIT;
                end else begin
                    mosi_d = tx_q[S-1];
                    tx_d   = {tx_q[S-2:0], 1'b0};
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                rx_d = {rx_q[126:0], miso_ext[sel_q]};
                // The result is published on the edge entering DONE so that
                // data_out is already valid while done is high.
                if (cnt_q == RECV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    dout_d  = rx_d;
                    done_d  = 1'b1;
                    cs_n_d  = '1;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sel_q   <= '0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sel_q   <= sel_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_spi_aes_multi_master.sv
// tb_spi_aes_multi_master
//   Two masters (Nk=4/GAP=4 and Nk=8/GAP=0) each driving a behavioural pair of
//   slaves: channel 0 is an AES cipher, channel 1 an AES inverse cipher.
`define CHK(TAG, OBS, EXP) \
    begin \
        tests++; \
        assert ((OBS) === (EXP)) else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

module tb_spi_aes_multi_master;

    logic clk;
    logic rst;

    logic         start_w [2];
    logic [1:0]   sel_w   [2];
    logic [127:0] data_w  [2];
    logic [255:0] key_w   [2];
    logic         mosi_o  [2];
    logic [1:0]   cs_o    [2];
    logic         busy_o  [2];
    logic         done_o  [2];
    logic         err_o   [2];
    logic [127:0] dout_o  [2];
    logic [127:0] last_out[2];

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t[256];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    // AES-128/192/256; the key occupies the low nk*32 bits of k.
    function automatic logic [127:0] aes(input logic [127:0] blk, input logic [255:0] k,
                                         input int nk, input bit inv);
        logic [31:0]  w[60];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[nk*32-1-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        if (!inv) begin
            for (int i = 0; i < 16; i++) s[i] ^= w[i/4][31-8*(i%4) -: 8];
            for (int r = 1; r <= nr; r++) begin
                for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
                s = t;
                if (r < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                        s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                    end
                end
                for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
            end
        end else begin
            for (int i = 0; i < 16; i++) s[i] ^= w[4*nr + i/4][31-8*(i%4) -: 8];
            for (int r = nr - 1; r >= 0; r--) begin
                for (int i = 0; i < 16; i++) t[i] = isbox_t[s[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]];
                s = t;
                for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
                if (r > 0) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
                        s[4*c+1] = gmul(a0, 9) ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
                        s[4*c+2] = gmul(a0, 13) ^ gmul(a1, 9) ^ gmul(a2, 14) ^ gmul(a3, 11);
                        s[4*c+3] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9) ^ gmul(a3, 14);
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // One master per generate slot, each with its own pair of slave models.
    for (genvar d = 0; d < 2; d++) begin : g_slot
        localparam int NK = (d == 0) ? 4 : 8;
        localparam int GP = (d == 0) ? 4 : 0;
        localparam int SS = 128 + NK * 32;

        logic [1:0]   miso;
        int           c;
        int           ch;
        logic [383:0] rx;
        logic [127:0] res;

        spi_aes_multi_master #(
            .Nk     (NK),
            .NUM_CH (2),
            .GAP    (GP),
            .SEL_W  (2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_w[d]),
            .sel      (sel_w[d]),
            .data_in  (data_w[d]),
            .key      (key_w[d][NK*32-1:0]),
            .miso     (miso),
            .mosi     (mosi_o[d]),
            .cs_n     (cs_o[d]),
            .busy     (busy_o[d]),
            .done     (done_o[d]),
            .err      (err_o[d]),
            .data_out (dout_o[d])
        );

        // Slave side: count cycles since chip-select fell, collect the stream,
        // and present the result one bit per cycle after the turnaround gap.
        // Idle MISO lines carry noise so a wrong-channel sample shows up.
        always @(negedge clk) begin
            logic [1:0]   r;
            logic [255:0] kk;
            r = 2'($urandom);
            if (!rst || cs_o[d] === 2'b11) begin
                c    = 0;
                rx   = '0;
                miso = r;
            end else begin
                c++;
                ch = (cs_o[d][0] === 1'b0) ? 0 : 1;
                if (c <= SS) rx = {rx[382:0], mosi_o[d]};
                if (c == SS) begin
                    kk = '0;
                    kk[NK*32-1:0] = rx[NK*32-1:0];
                    res = aes(rx[NK*32 +: 128], kk, NK, ch == 1);
                end
                miso = r;
                if (c > SS + GP && c <= SS + GP + 128) miso[ch] = res[127 - (c - SS - GP - 1)];
            end
        end
    end

    // Starts a transaction at the current negedge and follows it to done.
    task automatic txn(input int d, input logic [1:0] sel, input logic [127:0] blk,
                       input logic [255:0] k, input logic [127:0] exp, input bit hold);
        int lat, cyc, bad_cs, bad_busy, bad_err, bad_hold;
        lat = 128 + ((d == 0) ? 128 : 256) + ((d == 0) ? 4 : 0) + 129;
        start_w[d] = 1'b1;
        sel_w[d]   = sel;
        data_w[d]  = blk;
        key_w[d]   = k;
        cyc = 0; bad_cs = 0; bad_busy = 0; bad_err = 0; bad_hold = 0;
        while (done_o[d] !== 1'b1 && cyc < lat + 10) begin
            @(negedge clk);
            cyc++;
            if (!hold) start_w[d] = 1'b0;
            else       sel_w[d] = 2'($urandom);
            data_w[d] = {4{$urandom}};
            key_w[d]  = {8{$urandom}};
            if (cs_o[d] !== (done_o[d] === 1'b1 ? 2'b11 : ~(2'b01 << sel))) bad_cs++;
            if (busy_o[d] !== 1'b1) bad_busy++;
            if (err_o[d] !== 1'b0) bad_err++;
            if (done_o[d] !== 1'b1 && dout_o[d] !== last_out[d]) bad_hold++;
        end
        `CHK($sformatf("latency[%0d]", d), cyc, lat)
        `CHK($sformatf("data_out[%0d]", d), dout_o[d], exp)
        `CHK($sformatf("cs_n_cycles[%0d]", d), bad_cs, 0)
        `CHK($sformatf("busy_cycles[%0d]", d), bad_busy, 0)
        `CHK($sformatf("err_while_busy[%0d]", d), bad_err, 0)
        `CHK($sformatf("data_out_held[%0d]", d), bad_hold, 0)
        last_out[d] = exp;
    endtask

    task automatic after_done(input int d);
        @(negedge clk);
        `CHK($sformatf("post_busy[%0d]", d), busy_o[d], 1'b0)
        `CHK($sformatf("post_done[%0d]", d), done_o[d], 1'b0)
        `CHK($sformatf("post_cs_n[%0d]", d), cs_o[d], 2'b11)
    endtask

    initial begin
        logic [127:0] pt, ct, blk, rk;
        logic [255:0] k128, k256, kr;
        logic [1:0]   s;

        pt   = 128'h00112233445566778899aabbccddeeff;
        ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        k128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

        build_tables();

        // Reset held with random inputs
        rst = 1'b0;
        for (int d = 0; d < 2; d++) last_out[d] = '0;
        repeat (6) begin
            for (int d = 0; d < 2; d++) begin
                start_w[d] = 1'($urandom);
                sel_w[d]   = 2'($urandom);
                data_w[d]  = {4{$urandom}};
                key_w[d]   = {8{$urandom}};
            end
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            `CHK($sformatf("rst_mosi[%0d]", d), mosi_o[d], 1'b0)
            `CHK($sformatf("rst_cs_n[%0d]", d), cs_o[d], 2'b11)
            `CHK($sformatf("rst_busy[%0d]", d), busy_o[d], 1'b0)
            `CHK($sformatf("rst_done[%0d]", d), done_o[d], 1'b0)
            `CHK($sformatf("rst_err[%0d]", d), err_o[d], 1'b0)
            `CHK($sformatf("rst_data_out[%0d]", d), dout_o[d], 128'h0)
            start_w[d] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            `CHK($sformatf("rel_cs_n[%0d]", d), cs_o[d], 2'b11)
            `CHK($sformatf("rel_busy[%0d]", d), busy_o[d], 1'b0)
        end

        // Known-answer encrypt on channel 0, then decrypt on channel 1
        txn(0, 2'd0, pt, k128, ct, 1'b0);
        after_done(0);
        txn(0, 2'd1, ct, k128, pt, 1'b0);
        after_done(0);

        // Out-of-range selects are rejected with a single err pulse
        for (int v = 2; v < 4; v++) begin
            start_w[0] = 1'b1;
            sel_w[0]   = 2'(v);
            @(negedge clk);
            start_w[0] = 1'b0;
            `CHK($sformatf("err_pulse[sel=%0d]", v), err_o[0], 1'b1)
            `CHK($sformatf("err_busy[sel=%0d]", v), busy_o[0], 1'b0)
            `CHK($sformatf("err_cs_n[sel=%0d]", v), cs_o[0], 2'b11)
            @(negedge clk);
            `CHK($sformatf("err_one_cycle[sel=%0d]", v), err_o[0], 1'b0)
            `CHK($sformatf("err_still_idle[sel=%0d]", v), busy_o[0], 1'b0)
        end

        // Random blocks and keys on random channels
        repeat (3) begin
            s    = 2'($urandom_range(0, 1));
            blk  = {4{$urandom}};
            rk   = {4{$urandom}};
            kr   = {128'h0, rk};
            txn(0, s, blk, kr, aes(blk, kr, 4, s == 2'd1), 1'b0);
            after_done(0);
        end

        // Reset in SEND cycle 50 aborts the transfer immediately
        start_w[0] = 1'b1;
        sel_w[0]   = 2'd0;
        data_w[0]  = {4{$urandom}};
        key_w[0]   = {8{$urandom}};
        repeat (50) begin
            @(negedge clk);
            start_w[0] = 1'b0;
        end
        `CHK("abort_busy_before", busy_o[0], 1'b1)
        `CHK("abort_cs_before", cs_o[0], 2'b10)
        #2 rst = 1'b0;
        #1;
        `CHK("abort_cs_n", cs_o[0], 2'b11)
        `CHK("abort_busy", busy_o[0], 1'b0)
        `CHK("abort_mosi", mosi_o[0], 1'b0)
        `CHK("abort_data_out", dout_o[0], 128'h0)
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) last_out[d] = '0;
        @(negedge clk);
        blk = {4{$urandom}};
        kr  = {128'h0, {4{$urandom}}};
        txn(0, 2'd0, blk, kr, aes(blk, kr, 4, 1'b0), 1'b0);
        after_done(0);

        // Nk=8, GAP=0: start held high throughout, next start right after done
        txn(1, 2'd0, pt, k256, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1);
        after_done(1);
        blk = {4{$urandom}};
        kr  = {8{$urandom}};
        txn(1, 2'd1, blk, kr, aes(blk, kr, 8, 1'b1), 1'b0);
        after_done(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
